uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//   Byte FIFO that sits directly upstream of the UART transmitter and drives its
//   transmit/data_tx inputs. Producers push bytes at full clock rate; the block
//   launches one byte per UART frame and pops the next byte only after busy_tx
//   has risen and fallen again. Decouples bursty on-chip writers from the
//   115200-baud serial line.
// PARAMETERS
//   DEPTH  16  FIFO entries; must be a power of 2, >= 2
//   AW     4   pointer width, log2(DEPTH)
// PORTS
//   clk        in   1     system clock (50 MHz)
//   nRst       in   1     asynchronous active-low reset
//   wr_en      in   1     push wr_data this cycle
//   wr_data    in   8     byte to queue
//   ovf_clr    in   1     clear sticky overflow flag
//   full       out  1     count == DEPTH
//   empty      out  1     count == 0
//   count      out  AW+1  bytes held, excluding the byte in flight
//   overflow   out  1     sticky: a push was attempted while full
//   transmit   out  1     one-cycle launch strobe to the UART
//   data_tx    out  8     byte to the UART; stable from launch until next launch
//   busy_tx    in   1     UART transmitter busy
// BEHAVIOUR
//   Reset (async, nRst low): pointers=0, count=0, empty=1, full=0, overflow=0,
//     transmit=0, data_tx=8'h00, FSM=IDLE. Reset mid-frame discards all queued
//     bytes; the UART is reset by the same nRst.
//   Storage: DEPTH x 8 register array; wr_ptr/rd_ptr AW bits, wrap modulo DEPTH.
//   Push: accepted when wr_en && !full. Writes mem[wr_ptr]; wr_ptr+1.
//     Push while full is dropped: no state change except overflow<=1.
//     full is evaluated before any same-cycle pop, so full blocks the push even
//     when a pop occurs in the same cycle.
//   ovf_clr clears overflow. If ovf_clr and a dropped push coincide, overflow=1
//     (set wins).
//   count: +1 on push only, -1 on pop only, unchanged on both or neither.
//   FSM, all outputs registered:
//     IDLE      : if !empty && !busy_tx -> data_tx<=mem[rd_ptr], rd_ptr+1 (pop),
//                 transmit<=1, go LAUNCH.
//     LAUNCH    : transmit<=0, go WAIT_BUSY. transmit is high exactly 1 cycle.
//     WAIT_BUSY : if busy_tx go WAIT_DONE. Otherwise hold (no timeout).
//     WAIT_DONE : if !busy_tx go IDLE.
//     Any other encoding -> IDLE.
//   Latency: push into an empty FIFO with FSM in IDLE and busy_tx=0 at edge E
//     gives transmit=1 after edge E+1 (empty is registered; seen at E+1).
//   Back-to-back: after busy_tx falls, the next launch occurs 2 edges later
//     (WAIT_DONE->IDLE, then IDLE->LAUNCH). The UART is in TX_IDLE by then.
//   Pop and push in the same cycle are both honoured; pointers are independent.
//   data_tx holds the last launched byte while idle.
// TESTING
//   1 Reset: hold nRst=0 mid-frame -> all outputs at reset values; empty=1;
//     no transmit after release.
//   2 Single byte: push 8'hA5 into idle block -> transmit=1 for exactly 1 cycle,
//     2 cycles after push, data_tx=8'hA5; count returns to 0.
//   3 Burst: push 8'h01..8'h05 on consecutive cycles with the UART model attached
//     -> 5 launches in order 01..05, each only after busy_tx fell; serial line
//     decodes the same bytes.
//   4 Full/overflow: DEPTH=16, busy_tx held high, push 17 bytes -> full=1,
//     count=16, overflow=1, 17th byte absent from output; ovf_clr -> overflow=0.
//   5 Simultaneous: with count=3, push while IDLE pops -> count stays 3, order
//     preserved; pointer wrap verified after 40 bytes total.
//   6 Stall: busy_tx stuck low after launch -> FSM holds WAIT_BUSY, no relaunch,
//     transmit stays 0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: queues bytes at clock rate and launches
// one byte per frame, handshaking on the transmitter's busy flag.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          ovf_clr,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          transmit,
  output logic [7:0]    data_tx,
  input  logic          busy_tx
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  state_t        state;
  state_t        next_state;
  logic          push;
  logic          pop;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);
  // full is taken from the registered count, so a same-cycle pop never frees room
  assign push  = wr_en && !full;

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !busy_tx) begin
          pop        = 1'b1;
          next_state = LAUNCH;
        end
      end
      LAUNCH:    next_state = WAIT_BUSY;
      WAIT_BUSY: if (busy_tx) next_state = WAIT_DONE;
      WAIT_DONE: if (!busy_tx) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      transmit <= 1'b0;
      data_tx  <= 8'h00;
    end else begin
      state    <= next_state;
      transmit <= pop;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        data_tx <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // a dropped push outranks a clear in the same cycle
      if (wr_en && full) overflow <= 1'b1;
      else if (ovf_clr)  overflow <= 1'b0;
    end
  end

endmodule
